// File: rtl/seq_scan_pkg.sv
// Shared types and sizing for the sequential generator scan controller.
package seq_scan_pkg;

    localparam int NUM_GEN = 8;
    localparam int DATA_W  = 8;
    localparam int BURST_W = 4;
    localparam int IDX_W   = $clog2(NUM_GEN);
    localparam int CNT_W   = BURST_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_EMIT,
        ST_STEP,
        ST_NEXT
    } state_t;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_GEN-1:0] mask);
        lowest_set = '0;
        for (int i = NUM_GEN - 1; i >= 0; i--) begin
            if (mask[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    function automatic logic [NUM_GEN-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/seq_next_sel.sv
// Combinational finder: lowest set mask bit strictly above idx, with found flag.
module seq_next_sel
    import seq_scan_pkg::*;
(
    input  logic [NUM_GEN-1:0] mask,
    input  logic [IDX_W-1:0]   idx,
    output logic [IDX_W-1:0]   next_idx,
    output logic               found
);

    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_GEN; i++) begin
            if (!found && mask[i] && (i > int'(idx))) begin
                next_idx = IDX_W'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Walks selected generators: clear, read burst_len terms via valid/ready, step between terms.
// Optional SEQ_SCAN_LOOP_EN adds loop_en to restart the scan instead of idling.
module seq_scan_ctrl
    import seq_scan_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_GEN-1:0]        sel_mask,
    input  logic [BURST_W-1:0]        burst_len,
    input  logic [NUM_GEN*DATA_W-1:0] gen_val,
`ifdef SEQ_SCAN_LOOP_EN
    input  logic                      loop_en,
`endif
    output logic [NUM_GEN-1:0]        gen_clr,
    output logic [NUM_GEN-1:0]        gen_step,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IDX_W-1:0]          out_id,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    state_t              state;
    logic [NUM_GEN-1:0]  mask_q;
    logic [CNT_W-1:0]    burst_q;
    logic [CNT_W-1:0]    count;
    logic [IDX_W-1:0]    cur;
    logic [IDX_W-1:0]    next_idx;
    logic                found;
    logic                loop_go;
    logic [CNT_W-1:0]    count_inc;
    logic [DATA_W-1:0]   cur_val;

    seq_next_sel u_next_sel (
        .mask     (mask_q),
        .idx      (cur),
        .next_idx (next_idx),
        .found    (found)
    );

`ifdef SEQ_SCAN_LOOP_EN
    assign loop_go = loop_en;
`else
    assign loop_go = 1'b0;
`endif

    assign count_inc = count + CNT_W'(1);
    assign cur_val   = gen_val[DATA_W*int'(cur) +: DATA_W];
    assign busy      = (state != ST_IDLE);

    // Handshake: out_valid rises only on entry to EMIT and holds, with out_id/out_data/out_last
    // stable, until out_ready; a term transfers on a posedge where both are high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            mask_q    <= '0;
            burst_q   <= '0;
            count     <= '0;
            cur       <= '0;
            gen_clr   <= '0;
            gen_step  <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            gen_clr  <= '0;
            gen_step <= '0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (sel_mask != '0) begin
                            mask_q  <= sel_mask;
                            burst_q <= (burst_len == '0) ? CNT_W'(1 << BURST_W) : {1'b0, burst_len};
                            cur     <= lowest_set(sel_mask);
                            gen_clr <= onehot(lowest_set(sel_mask));
                            state   <= ST_CLEAR;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    count <= '0;
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    out_data  <= cur_val;
                    out_id    <= cur;
                    // Last term of the scan: final burst term and no selected generator above.
                    out_last  <= (count_inc == burst_q) && !found;
                    out_valid <= 1'b1;
                    state     <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        count     <= count_inc;
                        if (count_inc < burst_q) begin
                            gen_step <= onehot(cur);
                            state    <= ST_STEP;
                        end else begin
                            state <= ST_NEXT;
                        end
                    end
                end
                ST_STEP: begin
                    state <= ST_LOAD;
                end
                ST_NEXT: begin
                    if (found) begin
                        cur     <= next_idx;
                        gen_clr <= onehot(next_idx);
                        state   <= ST_CLEAR;
                    end else begin
                        done <= 1'b1;
                        if (loop_go) begin
                            cur     <= lowest_set(mask_q);
                            gen_clr <= onehot(lowest_set(mask_q));
                            state   <= ST_CLEAR;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state changes on posedge clk.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  in  1  begins a scan when sampled high in IDLE.
REQ-004 SHALL have port: sel_mask  in  8  generators included in the scan (bit i = generator i); sampled at accepted start.
REQ-005 SHALL have port: burst_len  in  4  terms per generator, 0 means 16; sampled at accepted start.
REQ-006 SHALL have port: gen_val  in  64  current generator outputs, generator i on bits [8i+7:8i].
REQ-007 SHALL have port: gen_clr  out  8  one-cycle reset pulse to generator i.
REQ-008 SHALL have port: gen_step  out  8  one-cycle advance pulse to generator i.
REQ-009 SHALL have port: out_valid / out_ready  out / in  1 / 1  output term handshake; transfer when both high.
REQ-010 SHALL have port: out_id / out_data / out_last  out  3 / 8 / 1  generator index, term value, final term of scan.
REQ-011 SHALL have port: busy / done  out  1 / 1  scan in progress / one-cycle end-of-scan pulse.

Function
REQ-012 SHALL implement FSM IDLE -> CLEAR -> LOAD -> EMIT -> (STEP -> LOAD | NEXT) -> CLEAR | IDLE.
REQ-013 SHALL in IDLE with start=1 and sel_mask!=0 capture mask and burst, set cur to lowest set bit, go to CLEAR.
REQ-014 SHALL with start=1 and sel_mask==0 stay IDLE and pulse done the next cycle; no gen_clr, no out_valid.
REQ-015 SHALL in CLEAR assert gen_clr[cur] for exactly one cycle, zero term count, go to LOAD.
REQ-016 SHALL in LOAD register gen_val[cur] into out_data and cur into out_id, go to EMIT.
REQ-017 SHALL in EMIT hold out_valid=1 with out_data/out_id/out_last stable until out_ready=1.
REQ-018 SHALL on transfer increment term count; if count < burst go STEP, else go NEXT.
REQ-019 SHALL in STEP assert gen_step[cur] for exactly one cycle, go to LOAD.
REQ-020 SHALL in NEXT select next set mask bit above cur, go to CLEAR; if none, pulse done and go IDLE.
REQ-021 SHALL drive out_last=1 only on the last term of the highest-index selected generator.
REQ-022 SHALL give latency: first out_valid 3 cycles after accepted start; next term out_valid 3 cycles after transfer.
REQ-023 SHALL ignore start while busy; busy=1 in every state except IDLE.
REQ-024 SHALL never assert more than one bit of gen_clr|gen_step in any cycle.

Reset
REQ-025 SHALL on reset force IDLE, gen_clr=0, gen_step=0, out_valid=0, out_data=0, out_id=0, out_last=0, busy=0, done=0, count=0, captured mask=0.
REQ-026 SHALL abort a scan on reset mid-operation with no trailing pulses; reset dominates start.

Configuration
REQ-027 SHALL with SEQ_SCAN_LOOP_EN defined add input loop_en (1 bit); at end of scan with loop_en=1, pulse done and return to CLEAR on lowest set bit instead of IDLE.
REQ-028 SHALL without SEQ_SCAN_LOOP_EN have no loop_en port and always return to IDLE at end of scan.

Structure
REQ-029 SHALL place state enum, NUM_GEN=8, DATA_W=8, BURST_W=4 in package seq_scan_pkg.
REQ-030 SHALL use one sub-module seq_next_sel: combinational next-set-bit-above-index finder returning index and found flag.

Verification
REQ-031 SHALL cover: mask=8'h08, burst=5, ready=1, Fibonacci model on slot 3 -> gen_clr[3] once, gen_step[3] x4, out_data 1,1,2,3,5, out_last on 5, done after.
REQ-032 SHALL cover: start with mask=8'h00 -> done at cycle+1, busy stays 0, no out_valid.
REQ-033 SHALL cover: mask=8'h81, burst=2 -> out_id 0,0,7,7; out_last only on fourth term.
REQ-034 SHALL cover: out_ready low 4 cycles during EMIT -> out_data/out_id constant, no gen_step.
REQ-035 SHALL cover: reset asserted during EMIT -> all outputs 0 next cycle; start=1 while busy ignored.
REQ-036 SHALL cover: burst_len=0 -> 16 terms emitted from a single-bit mask.
